// File: rtl/ccff_chain_loader_if.sv
// Host/chain-side signal bundle for the ccff chain loader.
// The slave modport is the loader; master is the host plus the chain itself.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail, rb_ready,
    output cfg_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done
  );

  modport master (
    output start, cfg_data, cfg_valid, ccff_tail, rb_ready,
    input  cfg_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial loader for a tile's ccff configuration chain.
// Shifts CHAIN_LEN bitstream bits into ccff_head (bit 0 of each word first)
// and packs the previous chain contents leaving ccff_tail into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input logic                prog_clk,
  input logic                prog_reset_n,
  ccff_chain_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SF_W  = $clog2(WORD_W + 1);
  localparam int RC_W  = $clog2(WORD_W);

  if (CHAIN_LEN < 1) begin : g_bad_len
    $error("ccff_chain_loader: CHAIN_LEN must be >= 1");
  end
  if (WORD_W < 2) begin : g_bad_word
    $error("ccff_chain_loader: WORD_W must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_bits_left;
  logic [SF_W-1:0]   r_sfill;
  logic [WORD_W-1:0] r_sreg;
  logic [WORD_W-1:0] r_rreg;
  logic [RC_W-1:0]   r_rcnt;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic              r_done;

  logic              w_start_ok;
  logic              w_stall;
  logic              w_cfg_ready;
  logic              w_accept;
  logic              w_shift;
  logic              w_last_bit;
  logic              w_word_done;
  logic              w_finish_done;
  logic [WORD_W-1:0] w_rreg_new;

  // Handshake and shift qualifiers derived from the current state
  always_comb begin
    w_start_ok    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_stall       = r_rb_valid && !bus.rb_ready;
    w_cfg_ready   = (r_state == S_LOAD) && (r_sfill == '0) && (r_bits_left != '0);
    w_accept      = bus.cfg_valid && w_cfg_ready;
    w_shift       = (r_state == S_LOAD) && (r_sfill != '0) && !w_stall;
    w_last_bit    = (r_bits_left == CNT_W'(1));
    w_word_done   = w_shift && ((r_rcnt == RC_W'(WORD_W - 1)) || w_last_bit);
    w_finish_done = (r_state == S_FINISH) && (w_state_nxt == S_DONE);
  end

  // Readback word with the bit currently at the chain tail merged in
  always_comb begin
    w_rreg_new         = r_rreg;
    w_rreg_new[r_rcnt] = bus.ccff_tail;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_shift && w_last_bit) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        if (!r_rb_valid || bus.rb_ready) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Shift/accept datapath, readback packing and done flag
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      r_bits_left <= '0;
      r_sfill     <= '0;
      r_sreg      <= '0;
      r_rreg      <= '0;
      r_rcnt      <= '0;
      r_rb_data   <= '0;
      r_rb_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_bits_left <= CNT_W'(CHAIN_LEN);
        r_sfill     <= '0;
        r_rreg      <= '0;
        r_rcnt      <= '0;
        r_done      <= 1'b0;
      end else begin
        // accept needs sfill==0 while shift needs sfill!=0, so they never coincide
        if (w_accept) begin
          r_sreg <= bus.cfg_data;
          if (32'(r_bits_left) >= WORD_W) r_sfill <= SF_W'(WORD_W);
          else                            r_sfill <= SF_W'(r_bits_left);
        end
        if (w_shift) begin
          r_sreg      <= r_sreg >> 1;
          r_sfill     <= r_sfill - SF_W'(1);
          r_bits_left <= r_bits_left - CNT_W'(1);
          if (w_word_done) begin
            r_rb_data <= w_rreg_new;
            r_rreg    <= '0;
            r_rcnt    <= '0;
          end else begin
            r_rreg <= w_rreg_new;
            r_rcnt <= r_rcnt + RC_W'(1);
          end
        end
        if (w_finish_done) r_done <= 1'b1;
      end

      // A completing word may overwrite the holding register only when it is
      // empty or being taken, which the shift stall guarantees.
      if (w_word_done)       r_rb_valid <= 1'b1;
      else if (bus.rb_ready) r_rb_valid <= 1'b0;
    end
  end

  assign bus.cfg_ready     = w_cfg_ready;
  assign bus.ccff_shift_en = w_shift;
  assign bus.ccff_head     = w_shift & r_sreg[0];
  assign bus.rb_data       = r_rb_data;
  assign bus.rb_valid      = r_rb_valid;
  assign bus.busy          = (r_state == S_LOAD) || (r_state == S_FINISH);
  assign bus.done          = r_done;

endmodule
